// File: rtl/subtract_seq_pkg.sv
// Shared definitions for the chunked sequential subtractor:
// FSM encoding and chunk-count / index-width derivation.
package subtract_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A single-chunk build still needs a 1-bit index register.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/subtract_seq_if.sv
// Operand/result handshake bundle for subtract_seq.
// The borrow signal exists only when SUBTRACT_SEQ_BORROW_EN is defined.
interface subtract_seq_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] abus;
   logic [WIDTH-1:0] bbus;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             busy;
`ifdef SUBTRACT_SEQ_BORROW_EN
   logic             borrow;
`endif

   modport master (
      output in_valid, abus, bbus, out_ready,
      input  in_ready, out_valid, out, busy
`ifdef SUBTRACT_SEQ_BORROW_EN
      , input borrow
`endif
   );

   modport slave (
      input  in_valid, abus, bbus, out_ready,
      output in_ready, out_valid, out, busy
`ifdef SUBTRACT_SEQ_BORROW_EN
      , output borrow
`endif
   );
endinterface

// File: rtl/subtract_seq_sub_chunk.sv
// Combinational CHUNK-bit subtract with borrow in/out: diff = a - b - bin.
module sub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] diff,
   output logic             bout
);
   logic [CHUNK:0] full;

   // Extra top bit goes to 1 exactly when the chunk result underflows.
   assign full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
   assign diff = full[CHUNK-1:0];
   assign bout = full[CHUNK];
endmodule

// File: rtl/subtract_seq.sv
// Sequential subtractor: WIDTH-bit a - b computed CHUNK bits per cycle, LSB chunk first.
// Optional final-borrow output enabled by SUBTRACT_SEQ_BORROW_EN.
module subtract_seq
   import subtract_seq_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic          clk,
   input  logic          rst,
   subtract_seq_if.slave bus
);
   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDXW   = idx_w(NCHUNK);

   state_t state, nstate;

   logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, res_q;
   logic [IDXW-1:0]              idx;
   logic                         brw;
   logic                         last;
   logic [CHUNK-1:0]             a_c, b_c, diff;
   logic                         bout;

   assign last = (idx == IDXW'(NCHUNK - 1));

   // Chunk selection by compare rather than indexing keeps NCHUNK=1 clean.
   always_comb begin
      a_c = '0;
      b_c = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx == IDXW'(i)) begin
            a_c = a_q[i];
            b_c = b_q[i];
         end
      end
   end

   sub_chunk #(.CHUNK(CHUNK)) u_sub (
      .a    (a_c),
      .b    (b_c),
      .bin  (brw),
      .diff (diff),
      .bout (bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate        = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = ~rst;
            if (bus.in_valid) nstate = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last) nstate = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         idx   <= '0;
         brw   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q <= bus.abus;
                  b_q <= bus.bbus;
                  idx <= '0;
                  brw <= 1'b0;
               end
            end
            RUN: begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (idx == IDXW'(i)) res_q[i] <= diff;
               end
               brw <= bout;
               idx <= last ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.out = res_q;
`ifdef SUBTRACT_SEQ_BORROW_EN
   // After the last chunk the running borrow is the final a < b flag.
   assign bus.borrow = brw;
`endif

endmodule

// File: tb/tb_subtract_seq.sv
// Scoreboard bench for subtract_seq: 64/16 and 8/8 instances against a plain a-b model.
module tb_subtract_seq;
   typedef struct {
      logic [63:0] d;
      logic        br;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   subtract_seq_if #(.WIDTH(64)) bus ();
   subtract_seq_if #(.WIDTH(8))  b8 ();

   subtract_seq #(.WIDTH(64), .CHUNK(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   subtract_seq #(.WIDTH(8),  .CHUNK(8))  dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

   int   cyc = 0;
   int   npass = 0;
   int   ntot = 0;
   exp_t q[$];
   exp_t q8[$];
   bit   rand_rdy = 1'b0;
   logic ov_prev = 1'b0;
   logic ov8_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   end

   // Monitors: latency on the rising edge of out_valid, data on each handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst) ov_prev = 1'b0;
      else begin
         if (bus.out_valid && !ov_prev) begin
            if (q.size() == 0) chk("spurious_valid64", 1, 0);
            else chk("latency64", 64'(cyc - q[0].acc), 64'd4);
         end
         if (bus.out_valid && bus.out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("out64", bus.out, e.d);
`ifdef SUBTRACT_SEQ_BORROW_EN
            chk("borrow64", 64'(bus.borrow), 64'(e.br));
`endif
         end
         ov_prev = bus.out_valid;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) ov8_prev = 1'b0;
      else begin
         if (b8.out_valid && !ov8_prev) begin
            if (q8.size() == 0) chk("spurious_valid8", 1, 0);
            else chk("latency8", 64'(cyc - q8[0].acc), 64'd1);
         end
         if (b8.out_valid && b8.out_ready && q8.size() != 0) begin
            e = q8.pop_front();
            chk("out8", 64'(b8.out), e.d);
`ifdef SUBTRACT_SEQ_BORROW_EN
            chk("borrow8", 64'(b8.borrow), 64'(e.br));
`endif
         end
         ov8_prev = b8.out_valid;
      end
   end

   task automatic op64(input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      int   n = 0;
      while (!bus.in_ready && n < 300) begin @(posedge clk); #1; n++; end
      if (n >= 300) chk("idle_timeout64", 0, 1);
      bus.abus = a; bus.bbus = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.abus = {$urandom, $urandom};
      bus.bbus = {$urandom, $urandom};
      e.d = a - b; e.br = (a < b); e.acc = cyc;
      q.push_back(e);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   n = 0;
      while (!b8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) chk("idle_timeout8", 0, 1);
      b8.abus = a; b8.bbus = b; b8.in_valid = 1'b1;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      b8.abus = 8'($urandom); b8.bbus = 8'($urandom);
      e.d = {56'd0, 8'(a - b)}; e.br = (a < b); e.acc = cyc;
      q8.push_back(e);
   endtask

   task automatic drain;
      int n = 0;
      while ((q.size() != 0 || q8.size() != 0) && n < 2000) begin @(posedge clk); #1; n++; end
      chk("drain", 64'(q.size() + q8.size()), 0);
   endtask

   initial begin
      logic [63:0] a, b, ebp;
      logic        seen;
      int          n;
      bus.in_valid = 1'b0; bus.abus = '0; bus.bbus = '0; bus.out_ready = 1'b1;
      b8.in_valid  = 1'b0; b8.abus  = '0; b8.bbus  = '0; b8.out_ready  = 1'b1;

      // Asynchronous reset between clock edges.
      #1 rst = 1'b1;
      #2;
      chk("rst_out", bus.out, 0);
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_out_valid8", 64'(b8.out_valid), 0);
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("rel_in_ready", 64'(bus.in_ready), 1);
      chk("rel_busy", 64'(bus.busy), 0);
      chk("rel_in_ready8", 64'(b8.in_ready), 1);

      op64(64'h0000_0001_0000_0000, 64'd1);
      op64(64'd0, 64'd1);
      op64(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
      op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      op64(64'h8000_0000_0000_0000, 64'd1);
      op64(64'd5, 64'hFFFF_FFFF_FFFF_FFFF);

      // Backpressure: hold the result in DONE while new operands wiggle.
      n = 0;
      while (!bus.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      bus.out_ready = 1'b0;
      a = 64'hDEAD_BEEF_0000_0000; b = 64'd1; ebp = a - b;
      op64(a, b);
      n = 0;
      while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_valid_seen", 64'(bus.out_valid), 1);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.abus = {$urandom, $urandom}; bus.bbus = {$urandom, $urandom};
         @(negedge clk);
         chk("bp_out_hold", bus.out, ebp);
         chk("bp_out_valid", 64'(bus.out_valid), 1);
         chk("bp_in_ready", 64'(bus.in_ready), 0);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_in_ready", 64'(bus.in_ready), 1);
      chk("bp_idle_out_valid", 64'(bus.out_valid), 0);
      chk("bp_out_retained", bus.out, ebp);

      // Randomized operands with random consumer stalls.
      rand_rdy = 1'b1;
      for (int k = 0; k < 30; k++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = {$urandom, $urandom};
            1:       b = a;
            2:       b = a + 64'($urandom_range(1, 70000));
            default: b = a - 64'($urandom_range(1, 70000));
         endcase
         op64(a, b);
      end
      rand_rdy = 1'b0;
      @(posedge clk); #2 bus.out_ready = 1'b1;
      drain();

      // Reset while chunk 2 is in flight: operation must vanish.
      op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_out", bus.out, 0);
      chk("midrst_out_valid", 64'(bus.out_valid), 0);
      chk("midrst_busy", 64'(bus.busy), 0);
      q.delete();
      #1 rst = 1'b0;
      #1 chk("midrst_in_ready", 64'(bus.in_ready), 1);
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
      chk("midrst_no_valid", 64'(seen), 0);
      @(posedge clk); #1;
      op64(64'd100, 64'd58);
      drain();

      // Single-chunk instance.
      op8(8'h10, 8'h20);
      for (int k = 0; k < 20; k++) op8(8'($urandom), 8'($urandom));
      drain();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/subtract_seq.md
SUBTRACT_SEQ -- requirements
Module: subtract_seq

Interface
REQ-001 Parameter WIDTH, default 64, total operand/result width in bits.
REQ-002 Parameter CHUNK, default 16, bits subtracted per cycle; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 abus  input  WIDTH  minuend.
REQ-008 bbus  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out  output  WIDTH  difference abus - bbus modulo 2^WIDTH.
REQ-012 busy  output  1  high in RUN or DONE.
REQ-013 borrow  output  1  final borrow (present only with SUBTRACT_SEQ_BORROW_EN).

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid & in_ready, capture abus/bbus, chunk index 0, internal borrow 0, go RUN; otherwise stay.
REQ-016 RUN: each cycle compute a[idx] - b[idx] - borrow on CHUNK bits, write difference into result chunk idx, update borrow, idx+1; after chunk NCHUNK-1 go DONE.
REQ-017 Chunk order SHALL be LSB chunk first; borrow SHALL propagate across every chunk boundary.
REQ-018 Latency: out_valid SHALL rise exactly NCHUNK clock edges after the accepting edge.
REQ-019 DONE: out, borrow, out_valid held stable until out_ready; on out_valid & out_ready go IDLE.
REQ-020 No acceptance in DONE; minimum spacing between accepts is NCHUNK+2 cycles.
REQ-021 in_valid, abus, bbus ignored outside IDLE; captured operands unaffected by later input changes.
REQ-022 Unsigned arithmetic; final borrow = 1 iff abus < bbus; out wraps modulo 2^WIDTH.
REQ-023 out SHALL retain the last result after the handshake until the next result overwrites it chunk by chunk (out only defined while out_valid).

Reset
REQ-024 rst asserted: state IDLE, out_valid 0, busy 0, in_ready 1 (once rst low), out 0, borrow 0, index 0, immediately and independent of clk.
REQ-025 rst during RUN or DONE SHALL abandon the operation; partial result discarded, no out_valid pulse.

Configuration
REQ-026 Macro SUBTRACT_SEQ_BORROW_EN defined: borrow port present, driven per REQ-022, valid while out_valid.
REQ-027 Macro undefined: borrow port absent; internal chunk borrow still used; out identical in both builds.

Structure
REQ-028 Shared package holds FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and NCHUNK/index-width derivation.
REQ-029 One sub-module sub_chunk: combinational CHUNK-bit a - b - bin -> diff, bout; instantiated once, reused every RUN cycle.

Verification
REQ-030 Reset: assert rst mid-cycle -> outputs 0 asynchronously; after release in_ready=1, busy=0.
REQ-031 WIDTH=64, CHUNK=16: a=0x0000_0001_0000_0000, b=1 -> out=0x0000_0000_FFFF_FFFF, borrow=0, out_valid exactly 4 edges after accept.
REQ-032 a=0, b=1 -> out=0xFFFF_FFFF_FFFF_FFFF, borrow=1; a=b=0x1234_5678_9ABC_DEF0 -> out=0, borrow=0.
REQ-033 Backpressure: out_ready low 5 cycles in DONE, in_valid toggling with new operands -> out/out_valid stable, in_ready 0, new operands not captured; out_ready high -> IDLE next edge.
REQ-034 rst pulsed during RUN chunk 2 -> IDLE, no out_valid; next op a=100, b=58 -> out=42.
REQ-035 WIDTH=CHUNK=8: a=0x10, b=0x20 -> out=0xF0, borrow=1, latency 1 edge; repeat with macro undefined -> out=0xF0, no borrow port.
